ifft4_stream: RTL and testbench
===============================

Name: ifft4_stream

Overview:
- Streaming 4-point inverse DFT, the inverse partner of the combinational fft4 forward transform.
- Accepts four frequency-domain complex samples X[0..3] serially over a valid/ready input port.
- Computes x[n] = (1/4)·Σ X[k]·W4^(−nk) in two registered radix-2 butterfly stages.
- Returns the four time-domain samples serially over a valid/ready output port; one frame is in flight at a time.

Parameters:
- DATA_W, 16, two's-complement width of each real/imag component, input and output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  in_re/in_im hold a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_re  input  DATA_W  real part of X[k], signed.
- in_im  input  DATA_W  imaginary part of X[k], signed.
- out_valid  output  1  out_re/out_im hold a result sample.
- out_ready  input  1  downstream accepts the result this cycle.
- out_re  output  DATA_W  real part of x[n], signed.
- out_im  output  DATA_W  imaginary part of x[n], signed.
- out_idx  output  2  index n of the current output sample.
- out_last  output  1  high with out_valid when out_idx==3.
- busy  output  1  high in any state other than LOAD with zero samples captured.

Behaviour:
- Reset (async, rst=1): state=LOAD, load count=0, send count=0, all sample and result registers cleared; in_ready=1, out_valid=0, out_re=out_im=0, out_idx=0, out_last=0, busy=0.
- Input transfer: occurs on a clk edge with in_valid&&in_ready. Samples arrive in natural order k=0,1,2,3 and are stored at the load count, which then increments.
- LOAD: in_ready=1. The transfer at count 3 captures X[3] and moves to BFLY1 on that edge.
- BFLY1 (1 cycle, in_ready=0): register, at DATA_W+1 bits:
  - a = X0+X2
  - b = X0−X2
  - c = X1+X3
  - d = X1−X3
- BFLY2 (1 cycle, in_ready=0): register, at DATA_W+2 bits:
  - x0 = a+c
  - x2 = a−c
  - x1 = b + j·d, i.e. re = b_re − d_im, im = b_im + d_re
  - x3 = b − j·d, i.e. re = b_re + d_im, im = b_im − d_re
  - Then scale each component by arithmetic shift right 2, truncating toward −inf, and keep the low DATA_W bits.
  - No overflow is possible, so no saturation logic is needed. Move to SEND.
- Latency: out_valid rises 2 cycles after the edge that accepted X[3].
- SEND: out_valid=1. out_re/out_im/out_idx present x[send count] in order n=0..3. On out_valid&&out_ready the send count increments.
  - The transfer with out_idx=3 (out_last=1) returns to LOAD, with load and send counts = 0.
  - Outputs are held stable while out_ready=0. Unlimited backpressure is allowed.
  - in_ready=0 throughout SEND. The next frame's X[0] is accepted no earlier than the cycle after the last output transfer.
- in_valid while in_ready=0: ignored; the sample is not consumed.
- in_valid low mid-frame in LOAD: the partial frame is retained indefinitely and the count is held.
- out_valid and out_last are registered; out_last = out_valid && out_idx==3.
- Reset asserted mid-frame (in any state): the frame is discarded and all outputs return to their reset values immediately. No partial output follows reset release.
- Round trip: ifft4_stream(fft4(x)) == x exactly for integer inputs whose fft4 outputs fit DATA_W.

Test Plan:
- Impulse at DC: X=(4,0),(0,0),(0,0),(0,0) -> x0..x3 all (1,0), out_idx 0..3, out_last only on idx 3, first out_valid 2 cycles after X3 accepted.
- Single tone: X=(0,0),(4,0),(0,0),(0,0) -> (1,0),(0,1),(−1,0),(0,−1).
- Round trip: X=(10,0),(−2,2),(−2,0),(−2,−2) (fft4 of 1,2,3,4) -> (1,0),(2,0),(3,0),(4,0).
- Truncation/sign and extremes:
  - X0=(3,0) -> all outputs (0,0).
  - X0=(−3,0) -> all outputs (−1,0).
  - All four X=(32767,−32768) -> x0=(32767,−32768), x1..x3=(0,0).
- Handshake stress: random in_valid gaps and out_ready held low 5 cycles on idx 1 -> outputs stable while stalled, in_ready=0 from X3 acceptance until the last output transfer, then back-to-back frames correct.
- Reset mid-operation:
  - rst pulse after X1 accepted -> in_ready=1, out_valid=0 immediately; a following full frame is computed correctly.
  - rst pulse during SEND idx 2 -> no further outputs.

Source files
------------

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse DFT: serial frame in, two registered radix-2
// butterfly stages with 1/4 scaling, serial frame out.

module ifft4_bfly #(
    parameter int W = 16
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    output logic [W:0]   sum,
    output logic [W:0]   diff
);
    logic [W:0] pe, qe;

    // One bit of growth, so the sign-extended add/sub cannot wrap.
    assign pe   = {p[W-1], p};
    assign qe   = {q[W-1], q};
    assign sum  = pe + qe;
    assign diff = pe - qe;
endmodule

module ifft4_stream #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              busy
);
    typedef enum logic [1:0] {LOAD, BFLY1, BFLY2, SEND} state_t;

    state_t state, state_nxt;
    logic [1:0] load_cnt, send_cnt;

    // comp 0 = real, comp 1 = imaginary
    logic [DATA_W-1:0] smp [2][4];
    logic [DATA_W:0]   a_d [2], b_d [2], c_d [2], d_d [2];
    logic [DATA_W:0]   a_q [2], b_q [2], c_q [2], d_q [2];
    logic [DATA_W+1:0] y0 [2], y1 [2], y2 [2], y3 [2];
    logic [DATA_W-1:0] res_re [4], res_im [4];

    for (genvar c = 0; c < 2; c++) begin : g_comp
        ifft4_bfly #(.W(DATA_W)) u_s1_02 (
            .p(smp[c][0]), .q(smp[c][2]), .sum(a_d[c]), .diff(b_d[c]));
        ifft4_bfly #(.W(DATA_W)) u_s1_13 (
            .p(smp[c][1]), .q(smp[c][3]), .sum(c_d[c]), .diff(d_d[c]));
        ifft4_bfly #(.W(DATA_W+1)) u_s2_ac (
            .p(a_q[c]), .q(c_q[c]), .sum(y0[c]), .diff(y2[c]));
    end

    // Inverse twiddle +j: x1 = b + j*d, x3 = b - j*d.
    ifft4_bfly #(.W(DATA_W+1)) u_s2_bd_re (
        .p(b_q[0]), .q(d_q[1]), .sum(y3[0]), .diff(y1[0]));
    ifft4_bfly #(.W(DATA_W+1)) u_s2_bd_im (
        .p(b_q[1]), .q(d_q[0]), .sum(y1[1]), .diff(y3[1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_cnt == 2'd3) state_nxt = BFLY1;
            end
            BFLY1: state_nxt = BFLY2;
            BFLY2: state_nxt = SEND;
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && send_cnt == 2'd3) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt <= '0;
            send_cnt <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 4; k++) smp[c][k] <= '0;
                a_q[c] <= '0;
                b_q[c] <= '0;
                c_q[c] <= '0;
                d_q[c] <= '0;
            end
            for (int n = 0; n < 4; n++) begin
                res_re[n] <= '0;
                res_im[n] <= '0;
            end
        end else begin
            if (in_valid && in_ready) begin
                smp[0][load_cnt] <= in_re;
                smp[1][load_cnt] <= in_im;
                load_cnt         <= load_cnt + 2'd1;
            end
            if (state == BFLY1) begin
                for (int c = 0; c < 2; c++) begin
                    a_q[c] <= a_d[c];
                    b_q[c] <= b_d[c];
                    c_q[c] <= c_d[c];
                    d_q[c] <= d_d[c];
                end
            end
            // Dropping the two LSBs is the floor-rounded divide by 4.
            if (state == BFLY2) begin
                res_re[0] <= y0[0][DATA_W+1:2];
                res_im[0] <= y0[1][DATA_W+1:2];
                res_re[1] <= y1[0][DATA_W+1:2];
                res_im[1] <= y1[1][DATA_W+1:2];
                res_re[2] <= y2[0][DATA_W+1:2];
                res_im[2] <= y2[1][DATA_W+1:2];
                res_re[3] <= y3[0][DATA_W+1:2];
                res_im[3] <= y3[1][DATA_W+1:2];
            end
            if (out_valid && out_ready) send_cnt <= send_cnt + 2'd1;
        end
    end

    assign out_re   = out_valid ? res_re[send_cnt] : '0;
    assign out_im   = out_valid ? res_im[send_cnt] : '0;
    assign out_idx  = send_cnt;
    assign out_last = out_valid && (send_cnt == 2'd3);
    assign busy     = !(state == LOAD && load_cnt == 2'd0);
endmodule

// File: tb/tb_ifft4_stream.sv
// Bench for ifft4_stream: fixed vector table, latency/handshake/reset
// sequences, and random frames against a direct inverse-DFT model.

module tb_ifft4_stream;
    localparam int W = 16;

    typedef logic [0:3][W-1:0] frame_t;
    typedef struct packed {
        frame_t xr, xi, er, ei;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [W-1:0] in_re, in_im, out_re, out_im;
    logic [1:0]   out_idx;

    int checks = 0, failures = 0;

    ifft4_stream #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // x[n] = floor((sum_k X[k] * j^(n*k)) / 4), truncated to W bits
    task automatic model(input frame_t xr, input frame_t xi, output frame_t er, output frame_t ei);
        for (int n = 0; n < 4; n++) begin
            int sr = 0, si = 0;
            for (int k = 0; k < 4; k++) begin
                int r = $signed(xr[k]);
                int i = $signed(xi[k]);
                case ((n * k) % 4)
                    0: begin sr += r;  si += i;  end
                    1: begin sr -= i;  si += r;  end
                    2: begin sr -= r;  si -= i;  end
                    default: begin sr += i;  si -= r;  end
                endcase
            end
            er[n] = W'(sr >>> 2);
            ei[n] = W'(si >>> 2);
        end
    endtask

    task automatic send_frame(input frame_t xr, input frame_t xi, input bit gaps, input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            int t = 0;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            in_valid = 1'b1;
            in_re    = xr[k];
            in_im    = xi[k];
            while (!in_ready && t < 20) begin tick(); t++; end
            chk("in_ready_timeout", int'(t < 20), 1);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic recv_frame(input frame_t er, input frame_t ei, input int stall_idx);
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            int t = 0;
            while (!out_valid && t < 20) begin tick(); t++; end
            chk("out_valid_timeout", int'(t < 20), 1);
            chk("out_idx", out_idx, n);
            chk("out_last", out_last, int'(n == 3));
            chk("out_re", $signed(out_re), $signed(er[n]));
            chk("out_im", $signed(out_im), $signed(ei[n]));
            chk("in_ready_send", in_ready, 0);
            if (n == stall_idx) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_idx", out_idx, n);
                    chk("stall_re", $signed(out_re), $signed(er[n]));
                    chk("stall_im", $signed(out_im), $signed(ei[n]));
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("end_in_ready", in_ready, 1);
        chk("end_out_valid", out_valid, 0);
        chk("end_busy", busy, 0);
    endtask

    vec_t   tbl [6];
    frame_t fr, fi, mr, mi;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;

        tbl[0] = '{xr: {16'd4, 16'd0, 16'd0, 16'd0}, xi: '0,
                   er: {16'd1, 16'd1, 16'd1, 16'd1}, ei: '0};
        tbl[1] = '{xr: {16'd0, 16'd4, 16'd0, 16'd0}, xi: '0,
                   er: {16'd1, 16'd0, -16'sd1, 16'd0}, ei: {16'd0, 16'd1, 16'd0, -16'sd1}};
        tbl[2] = '{xr: {16'd10, -16'sd2, -16'sd2, -16'sd2}, xi: {16'd0, 16'd2, 16'd0, -16'sd2},
                   er: {16'd1, 16'd2, 16'd3, 16'd4}, ei: '0};
        tbl[3] = '{xr: {16'd3, 16'd0, 16'd0, 16'd0}, xi: '0, er: '0, ei: '0};
        tbl[4] = '{xr: {-16'sd3, 16'd0, 16'd0, 16'd0}, xi: '0,
                   er: {-16'sd1, -16'sd1, -16'sd1, -16'sd1}, ei: '0};
        tbl[5] = '{xr: {16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff},
                   xi: {16'h8000, 16'h8000, 16'h8000, 16'h8000},
                   er: {16'h7fff, 16'h0, 16'h0, 16'h0}, ei: {16'h8000, 16'h0, 16'h0, 16'h0}};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].xr, tbl[i].xi, 1'b0, 4);
            if (i == 0) begin
                // Offered samples during the butterfly stages must be ignored.
                chk("lat_valid_0", out_valid, 0);
                chk("lat_busy", busy, 1);
                in_valid = 1'b1; in_re = 16'd777; in_im = 16'd555;
                tick();
                chk("lat_valid_1", out_valid, 0);
                chk("lat_in_ready", in_ready, 0);
                tick();
                chk("lat_valid_2", out_valid, 1);
                in_valid = 1'b0;
            end
            recv_frame(tbl[i].er, tbl[i].ei, -1);
        end

        // Handshake stress: input gaps plus 5-cycle stall on idx 1, back-to-back frames.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin fr[k] = W'($urandom); fi[k] = W'($urandom); end
            model(fr, fi, mr, mi);
            send_frame(fr, fi, 1'b1, 4);
            recv_frame(mr, mi, (f == 0) ? 1 : -1);
        end

        // Reset after X1 accepted.
        send_frame(tbl[2].xr, tbl[2].xi, 1'b0, 2);
        chk("partial_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        #4 rst = 1'b0;
        tick();
        send_frame(tbl[2].xr, tbl[2].xi, 1'b0, 4);
        recv_frame(tbl[2].er, tbl[2].ei, -1);

        // Reset while idx 2 is presented.
        send_frame(tbl[1].xr, tbl[1].xi, 1'b0, 4);
        out_ready = 1'b1;
        begin
            int t = 0;
            while (!(out_valid && out_idx == 2'd2) && t < 20) begin tick(); t++; end
            chk("send2_timeout", int'(t < 20), 1);
        end
        chk("send2_re", $signed(out_re), -1);
        #2 rst = 1'b1;
        #1;
        chk("sendrst_out_valid", out_valid, 0);
        chk("sendrst_out_idx", out_idx, 0);
        chk("sendrst_out_re", out_re, 0);
        #4 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_quiet", out_valid, 0);
        end

        // Random frames against the model with random gaps and stalls.
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 4; k++) begin fr[k] = W'($urandom); fi[k] = W'($urandom); end
            model(fr, fi, mr, mi);
            send_frame(fr, fi, 1'b1, 4);
            recv_frame(mr, mi, int'($urandom_range(0, 4)) - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
